fwd_stall_unit: RTL and testbench

- Parametrised successor to the pipeline bypass/stall logic. Generalises forwarding to NSTG producer stages behind EX, with per-stage data-ready flags.
- Adds a multi-cycle MUL/DIV busy tracker for HI/LO interlock, a one-cycle post-reset fetch hold, and a saturating stall-cycle performance counter.
- Sits between the pipeline registers and the PC/IF-ID write enables, the ID bubble mux, the ID-stage branch-operand muxes and the EX-stage operand muxes.

---
 rtl/fwd_stall_unit.sv | 140 ++++++++++++++
 tb/tb_fwd_stall_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_stall_unit.sv
// Operand-forwarding selects, hazard stall/bubble control, MUL/DIV busy tracking
// and a saturating stall-cycle counter for an in-order pipeline.
module fwd_stall_unit #(
    parameter int NSTG       = 3,
    parameter int SELW       = 2,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTG-1:0]   stg_wr,
    input  logic [5*NSTG-1:0] stg_rd,
    input  logic [NSTG-1:0]   stg_rdy,
    input  logic              ex_wr,
    input  logic [4:0]        ex_rd,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rs,
    input  logic [4:0]        ex_rt,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_early,
    input  logic              id_md_start,
    input  logic              id_md_div,
    input  logic              id_hilo_rd,
    input  logic              ex_flush,
    output logic [SELW-1:0]   ex_rs_sel,
    output logic [SELW-1:0]   ex_rt_sel,
    output logic [SELW-1:0]   id_rs_sel,
    output logic [SELW-1:0]   id_rt_sel,
    output logic              pc_wr,
    output logic              ifid_wr,
    output logic              inst_sram_en,
    output logic              id_bubble,
    output logic              stall,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int MD_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int MDW    = $clog2(MD_MAX + 1);

    // Scan oldest to youngest so the youngest matching stage is the last write.
    function automatic logic [SELW-1:0] fwd_sel(input logic [4:0]        src,
                                                input logic [NSTG-1:0]   wr,
                                                input logic [5*NSTG-1:0] rd);
        logic [SELW-1:0] sel;
        sel = '0;
        for (int k = NSTG; k >= 1; k--) begin
            if (wr[k-1] && (rd[5*k-1 -: 5] != 5'd0) && (rd[5*k-1 -: 5] == src))
                sel = SELW'(k);
        end
        return sel;
    endfunction

    function automatic logic not_ready(input logic [SELW-1:0] sel,
                                       input logic [NSTG-1:0] rdy);
        logic nr;
        nr = 1'b0;
        for (int k = 1; k <= NSTG; k++) begin
            if ((sel == SELW'(k)) && !rdy[k-1])
                nr = 1'b1;
        end
        return nr;
    endfunction

    logic [SELW-1:0] id_rs_win;
    logic [SELW-1:0] id_rt_win;
    logic            ex_hit;
    logic            h1, h2, h3, h4;
    logic            hazard;
    logic            hold_q;
    logic            run;
    logic            accept;
    logic [MDW-1:0]  md_cnt;

    assign ex_rs_sel = fwd_sel(ex_rs, stg_wr, stg_rd);
    assign ex_rt_sel = fwd_sel(ex_rt, stg_wr, stg_rd);
    assign id_rs_win = fwd_sel(id_rs, stg_wr, stg_rd);
    assign id_rt_win = fwd_sel(id_rt, stg_wr, stg_rd);
    assign id_rs_sel = id_early ? id_rs_win : '0;
    assign id_rt_sel = id_early ? id_rt_win : '0;

    assign ex_hit = ex_wr && (ex_rd != 5'd0) &&
                    ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));
    assign h1     = ex_is_load && ex_hit;
    assign h2     = id_early && ex_hit;
    assign h3     = (id_rs_used && not_ready(id_rs_win, stg_rdy)) ||
                    (id_rt_used && not_ready(id_rt_win, stg_rdy));
    assign h4     = md_busy && (id_hilo_rd || id_md_start);
    assign hazard = h1 || h2 || h3 || h4;

    // A flush must redirect fetch even while a hazard is pending.
    always_comb begin
        run = 1'b1;
        if (rst || hold_q)
            run = 1'b0;
        else if (ex_flush)
            run = 1'b1;
        else if (hazard)
            run = 1'b0;
    end

    assign pc_wr        = run;
    assign ifid_wr      = run;
    assign inst_sram_en = run;
    assign id_bubble    = ~run;
    assign stall        = ~run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_q <= 1'b1;
        else
            hold_q <= 1'b0;
    end

    // A running op is older than any flush, so only reset stops the count.
    assign accept = id_md_start && !stall && !ex_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            md_cnt <= '0;
        else if (accept)
            md_cnt <= id_md_div ? MDW'(DIV_CYCLES) : MDW'(MUL_CYCLES);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - MDW'(1);
    end

    assign md_busy = (md_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && !hold_q && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Directed scoreboard bench for fwd_stall_unit; a narrow stall counter makes
// saturation reachable within a short run.
module tb_fwd_stall_unit;

    localparam int NSTG  = 3;
    localparam int SELW  = 2;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int S_EXRS = 0, S_EXRT = 1, S_IDRS = 2, S_IDRT = 3, S_PCWR = 4,
                   S_IFID = 5, S_SRAM = 6, S_BUB = 7, S_STALL = 8, S_MDB = 9,
                   S_SCNT = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NSTG-1:0]   stg_wr;
    logic [5*NSTG-1:0] stg_rd;
    logic [NSTG-1:0]   stg_rdy;
    logic              ex_wr, ex_is_load;
    logic [4:0]        ex_rd, ex_rs, ex_rt, id_rs, id_rt;
    logic              id_rs_used, id_rt_used, id_early;
    logic              id_md_start, id_md_div, id_hilo_rd, ex_flush;
    logic [SELW-1:0]   ex_rs_sel, ex_rt_sel, id_rs_sel, id_rt_sel;
    logic              pc_wr, ifid_wr, inst_sram_en, id_bubble, stall, md_busy;
    logic [CNT_W-1:0]  stall_cnt;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;
    bit   exp_stall_counts = 1'b0;

    fwd_stall_unit #(
        .NSTG(NSTG), .SELW(SELW), .MUL_CYCLES(4), .DIV_CYCLES(33), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stg_wr(stg_wr), .stg_rd(stg_rd), .stg_rdy(stg_rdy),
        .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_early(id_early), .id_md_start(id_md_start), .id_md_div(id_md_div),
        .id_hilo_rd(id_hilo_rd), .ex_flush(ex_flush),
        .ex_rs_sel(ex_rs_sel), .ex_rt_sel(ex_rt_sel), .id_rs_sel(id_rs_sel), .id_rt_sel(id_rt_sel),
        .pc_wr(pc_wr), .ifid_wr(ifid_wr), .inst_sram_en(inst_sram_en), .id_bubble(id_bubble),
        .stall(stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_EXRS:  return 32'(ex_rs_sel);
            S_EXRT:  return 32'(ex_rt_sel);
            S_IDRS:  return 32'(id_rs_sel);
            S_IDRT:  return 32'(id_rt_sel);
            S_PCWR:  return 32'(pc_wr);
            S_IFID:  return 32'(ifid_wr);
            S_SRAM:  return 32'(inst_sram_en);
            S_BUB:   return 32'(id_bubble);
            S_STALL: return 32'(stall);
            S_MDB:   return 32'(md_busy);
            default: return 32'(stall_cnt);
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    // counts: whether this cycle's stall should advance the stall counter.
    task automatic push_ctrl(input string tag, input bit stl, input bit counts);
        push_exp({tag, "_pc_wr"}, S_PCWR, 32'(!stl));
        push_exp({tag, "_ifid_wr"}, S_IFID, 32'(!stl));
        push_exp({tag, "_sram_en"}, S_SRAM, 32'(!stl));
        push_exp({tag, "_bubble"}, S_BUB, 32'(stl));
        push_exp({tag, "_stall"}, S_STALL, 32'(stl));
        push_exp({tag, "_stall_cnt"}, S_SCNT, 32'(exp_cnt));
        exp_stall_counts = stl && counts;
    endtask

    task automatic checkOutput();
        logic [31:0] o;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            o = observe(e.sig);
            total++;
            assert (o === e.val)
            else begin
                bad++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        if (exp_stall_counts && exp_cnt != CNT_MAX)
            exp_cnt++;
        exp_stall_counts = 1'b0;
        #1;
    endtask

    task automatic set_idle();
        stg_wr = '0; stg_rd = '0; stg_rdy = '1;
        ex_wr = 0; ex_rd = 0; ex_is_load = 0; ex_rs = 0; ex_rt = 0;
        id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0; id_early = 0;
        id_md_start = 0; id_md_div = 0; id_hilo_rd = 0; ex_flush = 0;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        push_ctrl("rst", 1, 0);
        push_exp("rst_md_busy", S_MDB, 0);
        push_exp("rst_ex_rs_sel", S_EXRS, 0);
        applyStimulus();

        rst = 1'b0;
        push_ctrl("hold", 1, 0);
        applyStimulus();
        push_ctrl("post_hold", 0, 0);
        applyStimulus();

        stg_wr = 3'b011;
        stg_rd = {5'd3, 5'd7, 5'd7};
        ex_rs = 5'd7; ex_rt = 5'd3;
        id_rs = 5'd7; id_rs_used = 1;
        push_exp("fwd_youngest", S_EXRS, 1);
        push_exp("fwd_stage3_nowr", S_EXRT, 0);
        push_exp("id_sel_not_early", S_IDRS, 0);
        push_ctrl("fwd_a", 0, 0);
        applyStimulus();

        stg_rd = {5'd3, 5'd7, 5'd0};
        stg_wr = 3'b111;
        push_exp("fwd_skip_r0", S_EXRS, 2);
        push_exp("fwd_stage3", S_EXRT, 3);
        push_ctrl("fwd_b", 0, 0);
        applyStimulus();

        set_idle();
        ex_is_load = 1; ex_wr = 1; ex_rd = 5'd5; id_rt = 5'd5; id_rt_used = 1;
        for (int i = 0; i < 5; i++) begin
            push_ctrl("load_use", 1, 1);
            applyStimulus();
        end
        id_rt_used = 0;
        push_ctrl("load_unused", 0, 0);
        push_exp("stall_cnt_5", S_SCNT, 5);
        applyStimulus();
        ex_rd = 5'd0; id_rt = 5'd0; id_rt_used = 1;
        push_ctrl("load_r0", 0, 0);
        applyStimulus();

        set_idle();
        id_early = 1; stg_wr = 3'b001; stg_rd = {5'd0, 5'd0, 5'd9};
        stg_rdy = 3'b110; id_rs = 5'd9; id_rs_used = 1;
        push_ctrl("not_ready", 1, 1);
        push_exp("not_ready_id_sel", S_IDRS, 1);
        applyStimulus();
        stg_rdy = 3'b111;
        push_ctrl("ready", 0, 0);
        push_exp("ready_id_sel", S_IDRS, 1);
        applyStimulus();
        id_early = 0;
        push_exp("late_id_sel_zero", S_IDRS, 0);
        push_ctrl("late", 0, 0);
        applyStimulus();

        set_idle();
        id_early = 1; ex_wr = 1; ex_rd = 5'd9; id_rt = 5'd9; id_rt_used = 1;
        push_ctrl("early_ex", 1, 1);
        applyStimulus();

        set_idle();
        ex_is_load = 1; ex_wr = 1; ex_rd = 5'd5; id_rt = 5'd5; id_rt_used = 1;
        ex_flush = 1; id_md_start = 1; id_md_div = 1;
        push_ctrl("flush", 0, 0);
        applyStimulus();
        set_idle();
        push_exp("flush_no_md", S_MDB, 0);
        push_ctrl("after_flush", 0, 0);
        applyStimulus();

        id_md_start = 1; id_md_div = 1;
        push_exp("div_accept_busy", S_MDB, 0);
        push_ctrl("div_accept", 0, 0);
        applyStimulus();
        id_md_start = 0; id_hilo_rd = 1;
        for (int i = 0; i < 33; i++) begin
            push_exp("div_busy", S_MDB, 1);
            push_ctrl("div_hilo", 1, 1);
            applyStimulus();
        end
        push_exp("div_done", S_MDB, 0);
        push_exp("stall_cnt_sat", S_SCNT, CNT_MAX);
        push_ctrl("div_release", 0, 0);
        applyStimulus();

        id_hilo_rd = 0; id_md_start = 1; id_md_div = 0;
        push_ctrl("mul_accept", 0, 0);
        applyStimulus();
        for (int i = 0; i < 4; i++) begin
            push_exp("mul_busy", S_MDB, 1);
            push_ctrl("mul_restart", 1, 1);
            applyStimulus();
        end
        push_exp("mul_idle_edge", S_MDB, 0);
        push_ctrl("mul_reaccept", 0, 0);
        applyStimulus();
        id_md_start = 0;
        push_exp("mul2_busy", S_MDB, 1);
        push_ctrl("mul2_run", 0, 0);
        applyStimulus();

        rst = 1'b1;
        #1;
        exp_cnt = 0;
        push_exp("async_rst_md_busy", S_MDB, 0);
        push_exp("async_rst_cnt", S_SCNT, 0);
        push_exp("async_rst_pc_wr", S_PCWR, 0);
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_ctrl("hold2", 1, 0);
        applyStimulus();
        push_ctrl("post_hold2", 0, 0);
        push_exp("post_hold2_md", S_MDB, 0);
        applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
